// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer for a single-port RAM.
// One access every three cycles: IDLE grant, ACCESS drive, RESP pulse.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_0_valid,
  output logic                  req_0_ready,
  input  logic                  req_0_we,
  input  logic [ADDR_WIDTH-1:0] req_0_addr,
  input  logic [DATA_WIDTH-1:0] req_0_wdata,
  output logic                  rsp_0_valid,
  output logic [DATA_WIDTH-1:0] rsp_0_rdata,
  input  logic                  req_1_valid,
  output logic                  req_1_ready,
  input  logic                  req_1_we,
  input  logic [ADDR_WIDTH-1:0] req_1_addr,
  input  logic [DATA_WIDTH-1:0] req_1_wdata,
  output logic                  rsp_1_valid,
  output logic [DATA_WIDTH-1:0] rsp_1_rdata,
  output logic                  ram_w_enable,
  output logic [ADDR_WIDTH-1:0] ram_data_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic grant0, grant1;

  // Contention goes to whoever did not win last time.
  assign grant0 = req_0_valid & (~req_1_valid | last_q);
  assign grant1 = req_1_valid & (~req_0_valid | ~last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_0_ready = 1'b0;
    req_1_ready = 1'b0;
    rsp_0_valid = 1'b0;
    rsp_1_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_0_ready = grant0 & rst_n;
        req_1_ready = grant1 & rst_n;
        unique case (1'b1)
          grant0: begin
            we_d    = req_0_we;
            addr_d  = req_0_addr;
            wdata_d = req_0_wdata;
            owner_d = 1'b0;
            last_d  = 1'b0;
            state_d = ACCESS;
          end
          grant1: begin
            we_d    = req_1_we;
            addr_d  = req_1_addr;
            wdata_d = req_1_wdata;
            owner_d = 1'b1;
            last_d  = 1'b1;
            state_d = ACCESS;
          end
          default: ;
        endcase
      end
      ACCESS: begin
        rdata_d = we_q ? '0 : ram_data_out;
        state_d = RESP;
      end
      RESP: begin
        rsp_0_valid = ~owner_q;
        rsp_1_valid = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_w_enable  = (state_q == ACCESS) & we_q;
  assign ram_data_addr = addr_q;
  assign ram_data_in   = wdata_q;
  assign rsp_0_rdata   = rdata_q;
  assign rsp_1_rdata   = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter with a behavioural RAM.
// Inputs change and outputs are sampled around the falling edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 0, we0 = 0, v1 = 0, we1 = 0;
  logic [7:0]  a0 = 0, a1 = 0;
  logic [31:0] d0 = 0, d1 = 0;
  logic        r0, r1, s0, s1, wen;
  logic [31:0] q0, q1, din, dout;
  logic [7:0]  addr;
  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (wen) mem[addr] <= din;
  assign dout = mem[addr];

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_0_valid(v0), .req_0_ready(r0),
    .req_0_we(we0), .req_0_addr(a0),
    .req_0_wdata(d0), .rsp_0_valid(s0),
    .rsp_0_rdata(q0),
    .req_1_valid(v1), .req_1_ready(r1),
    .req_1_we(we1), .req_1_addr(a1),
    .req_1_wdata(d1), .rsp_1_valid(s1),
    .rsp_1_rdata(q1),
    .ram_w_enable(wen), .ram_data_addr(addr),
    .ram_data_in(din), .ram_data_out(dout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One transaction from a single requester, checked cycle by cycle.
  task automatic xact(input int p, input logic we,
                      input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    bit ok = 0;
    @(negedge clk);
    if (p == 0) begin v0 = 1; we0 = we; a0 = a; d0 = d; end
    else        begin v1 = 1; we1 = we; a1 = a; d1 = d; end
    for (int i = 0; i < 10; i++) begin
      #1;
      if ((p == 0) ? r0 : r1) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("grant", 32'(ok), 32'd1);
    @(negedge clk);
    v0 = 0; v1 = 0;
    chk("acc_wen", 32'(wen), 32'(we));
    chk("acc_addr", 32'(addr), 32'(a));
    @(negedge clk);
    chk("rsp_own", 32'((p == 0) ? s0 : s1), 32'd1);
    chk("rsp_oth", 32'((p == 0) ? s1 : s0), 32'd0);
    chk("rsp_wen", 32'(wen), 32'd0);
    chk("rsp_data", (p == 0) ? q0 : q1, exp);
  endtask

  initial begin
    bit exp_g;
    int grants;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[3] = 32'h0000_0055;

    // reset defaults, ready blocked during reset
    v0 = 1;
    #12;
    chk("rst_ready0", 32'(r0), 32'd0);
    chk("rst_wen", 32'(wen), 32'd0);
    v0 = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_out", {26'd0, r0, r1, s0, s1, wen, 1'b0}, 32'd0);
    end
    chk("idle_addr", 32'(addr), 32'd0);
    chk("idle_din", din, 32'd0);
    chk("idle_rdata", q0 | q1, 32'd0);

    // write then read from two requesters
    xact(0, 1, 8'h00, 32'h0000_BA7E, 32'd0);
    xact(1, 0, 8'h00, 32'd0, 32'h0000_BA7E);

    // simultaneous requests: last grant was 1, so 0 wins
    @(negedge clk);
    v0 = 1; we0 = 1; a0 = 8'h01; d0 = 32'h0000_BEBE;
    v1 = 1; we1 = 0; a1 = 8'h01; d1 = 32'd0;
    #1;
    chk("sim_r0", 32'(r0), 32'd1);
    chk("sim_r1", 32'(r1), 32'd0);
    @(negedge clk);
    v0 = 0;
    chk("sim_wen", 32'(wen), 32'd1);
    chk("sim_r1_acc", 32'(r1), 32'd0);
    @(negedge clk);
    chk("sim_rsp0", 32'(s0), 32'd1);
    chk("sim_r1_rsp", 32'(r1), 32'd0);
    @(negedge clk);
    chk("sim_r1_late", 32'(r1), 32'd1);
    @(negedge clk);
    v1 = 0;
    @(negedge clk);
    chk("sim_rsp1", 32'(s1), 32'd1);
    chk("sim_rd", q1, 32'h0000_BEBE);

    // sustained contention: 0,1,0,1,...
    @(negedge clk);
    v0 = 1; we0 = 0; a0 = 8'h00;
    v1 = 1; we1 = 0; a1 = 8'h01;
    grants = 0;
    exp_g = 0;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      #1;
      if (s0 & s1) chk("rsp_overlap", 32'd1, 32'd0);
      if (r0 | r1) begin
        chk("rr_one", 32'(r0 ^ r1), 32'd1);
        chk("rr_order", 32'(r1), 32'(exp_g));
        exp_g = ~exp_g;
        grants++;
      end
      @(negedge clk);
    end
    v0 = 0; v1 = 0;
    chk("rr_count", 32'(grants), 32'd8);
    @(negedge clk);
    @(negedge clk);

    // boundary address
    xact(0, 1, 8'hFF, 32'hFFFF_FFFF, 32'd0);
    xact(1, 0, 8'hFF, 32'd0, 32'hFFFF_FFFF);
    xact(0, 0, 8'h00, 32'd0, 32'h0000_BA7E);

    // reset across the ACCESS edge of a write
    @(negedge clk);
    v0 = 1; we0 = 1; a0 = 8'h03; d0 = 32'h0000_00AA;
    #1;
    chk("mid_grant", 32'(r0), 32'd1);
    @(negedge clk);
    v0 = 0;
    chk("mid_wen", 32'(wen), 32'd1);
    rst_n = 0;
    #1;
    chk("mid_wen_drop", 32'(wen), 32'd0);
    @(negedge clk);
    chk("mid_norsp", 32'(s0 | s1), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("mid_norsp2", 32'(s0 | s1), 32'd0);
    xact(1, 0, 8'h03, 32'd0, 32'h0000_0055);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
